// File: rtl/product_register.sv
// Running-product register for a 32x32 shift-add multiplier: {carry, upper sum, multiplier}.
// Optional macro PRODUCT_CARRY_EN keeps the ALU carry as a 65th bit that feeds bit 63 on shifts.
module product_register #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  srl_ctrl,
  input  logic                  w_ctrl,
  input  logic                  ready,
  input  logic                  ALU_Carry,
  input  logic [DATA_W-1:0]     ALU_result,
  input  logic [DATA_W-1:0]     Multiplier_in,
  output logic [2*DATA_W-1:0]   Product_out
);

  logic [2*DATA_W-1:0] p_q, p_d;
  logic                shift_fill;  // bit entering the MSB on a plain right shift
  logic                write_fill;  // bit entering the MSB on a combined write+shift

`ifdef PRODUCT_CARRY_EN
  logic c_q, c_d;

  assign shift_fill = c_q;
  assign write_fill = ALU_Carry;
`else
  logic unused_carry;

  assign unused_carry = ALU_Carry;
  assign shift_fill   = 1'b0;
  assign write_fill   = 1'b0;
`endif

  always_comb begin
    p_d = p_q;
`ifdef PRODUCT_CARRY_EN
    c_d = c_q;
`endif
    if (ready) begin
      p_d = p_q;
    end else if (w_ctrl && srl_ctrl) begin
      p_d = {write_fill, ALU_result, p_q[DATA_W-1:1]};
`ifdef PRODUCT_CARRY_EN
      c_d = 1'b0;
`endif
    end else if (w_ctrl) begin
      p_d = {ALU_result, p_q[DATA_W-1:0]};
`ifdef PRODUCT_CARRY_EN
      c_d = ALU_Carry;
`endif
    end else if (srl_ctrl) begin
      p_d = {shift_fill, p_q[2*DATA_W-1:1]};
`ifdef PRODUCT_CARRY_EN
      c_d = 1'b0;
`endif
    end
  end

  // Reset doubles as the multiplier load and aborts any run in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_q <= {{DATA_W{1'b0}}, Multiplier_in};
`ifdef PRODUCT_CARRY_EN
      c_q <= 1'b0;
`endif
    end else begin
      p_q <= p_d;
`ifdef PRODUCT_CARRY_EN
      c_q <= c_d;
`endif
    end
  end

  assign Product_out = p_q;

endmodule

// File: tb/tb_product_register.sv
// Directed checks of the product register, acting as control FSM and ALU for a full multiply.
module tb_product_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        srl_ctrl;
  logic        w_ctrl;
  logic        ready;
  logic        ALU_Carry;
  logic [31:0] ALU_result;
  logic [31:0] Multiplier_in;
  logic [63:0] Product_out;

  int total = 0;
  int bad   = 0;

  product_register #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .srl_ctrl(srl_ctrl), .w_ctrl(w_ctrl), .ready(ready),
    .ALU_Carry(ALU_Carry), .ALU_result(ALU_result), .Multiplier_in(Multiplier_in),
    .Product_out(Product_out)
  );

  always #5 clk = ~clk;

`ifdef PRODUCT_CARRY_EN
  localparam logic [63:0] EXP_CSHIFT1 = 64'h8000_0005_7FFF_FFFF;
  localparam logic [63:0] EXP_CSHIFT2 = 64'h4000_0002_BFFF_FFFF;
`else
  localparam logic [63:0] EXP_CSHIFT1 = 64'h0000_0005_7FFF_FFFF;
  localparam logic [63:0] EXP_CSHIFT2 = 64'h0000_0002_BFFF_FFFF;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] exp);
    total++;
    assert (Product_out === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, Product_out, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, Product_out, exp);
  endtask

  task automatic idle_ctrl();
    srl_ctrl = 1'b0; w_ctrl = 1'b0; ready = 1'b0; ALU_Carry = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] m);
    reset = 1'b0; Multiplier_in = m;
    step();
    reset = 1'b1;
  endtask

  // One multiply iteration: add-and-shift if the LSB is set, otherwise shift only.
  task automatic mul_iter(input logic [31:0] mcand);
    logic [32:0] sum;
    sum = {1'b0, Product_out[63:32]} + {1'b0, mcand};
    srl_ctrl = 1'b1;
    w_ctrl   = Product_out[0];
    {ALU_Carry, ALU_result} = sum;
    step();
    idle_ctrl();
  endtask

  initial begin
    reset = 1'b0; Multiplier_in = 32'hFFFF_FFFF; ALU_result = 32'h0;
    idle_ctrl();
    #1;
    step();
    chk("reset_load", 64'h0000_0000_FFFF_FFFF);

    reset = 1'b1; Multiplier_in = 32'h1234_5678;
    step();
    chk("idle_hold", 64'h0000_0000_FFFF_FFFF);

    w_ctrl = 1'b1; ALU_result = 32'd10; ALU_Carry = 1'b0;
    step();
    chk("write", 64'h0000_000A_FFFF_FFFF);

    w_ctrl = 1'b0; ALU_result = 32'hDEAD_BEEF; srl_ctrl = 1'b1;
    step();
    chk("shift", 64'h0000_0005_7FFF_FFFF);

    idle_ctrl();
    step();
    chk("hold_after_sh", 64'h0000_0005_7FFF_FFFF);

    reset = 1'b0; Multiplier_in = 32'hFFFF_FFFF;
    ready = 1'b1; w_ctrl = 1'b1; srl_ctrl = 1'b1;
    step();
    chk("reset_wins", 64'h0000_0000_FFFF_FFFF);
    reset = 1'b1; idle_ctrl();

    w_ctrl = 1'b1; ALU_result = 32'd10; ALU_Carry = 1'b1;
    step();
    chk("write_carry", 64'h0000_000A_FFFF_FFFF);
    idle_ctrl(); srl_ctrl = 1'b1;
    step();
    chk("carry_shift1", EXP_CSHIFT1);
    step();
    chk("carry_shift2", EXP_CSHIFT2);
    idle_ctrl();

    do_reset(32'hFFFF_FFFF);
    w_ctrl = 1'b1; srl_ctrl = 1'b1; ALU_result = 32'd10; ALU_Carry = 1'b1;
    step();
    chk("write_shift", EXP_CSHIFT1);

    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALU_result = 32'h1111_1111 * (i + 2);
      Multiplier_in = 32'h0F0F_0000 + i;
      step();
      chk($sformatf("freeze%0d", i), EXP_CSHIFT1);
    end
    reset = 1'b0; Multiplier_in = 32'hCAFE_BABE;
    step();
    chk("freeze_reset", 64'h0000_0000_CAFE_BABE);
    reset = 1'b1; idle_ctrl();

    do_reset(32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) mul_iter(32'h0000_0003);
    reset = 1'b0; Multiplier_in = 32'hFFFF_FFFF; srl_ctrl = 1'b1; w_ctrl = 1'b1;
    step();
    chk("abort_reload", 64'h0000_0000_FFFF_FFFF);
    reset = 1'b1; idle_ctrl();
    for (int i = 0; i < 32; i++) mul_iter(32'h0000_0003);
    chk("mul_result", 64'h0000_0002_FFFF_FFFD);

    ready = 1'b1; srl_ctrl = 1'b1; w_ctrl = 1'b1; ALU_result = 32'h5555_5555;
    step();
    step();
    chk("result_frozen", 64'h0000_0002_FFFF_FFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_register.md
# product_register

Product register of a 32×32 shift-add sequential multiplier. It holds the 64-bit running product: the multiplier in the low half and the partial sum in the high half. An ALU carry bit is kept as a 65th bit. It sits between the adder (ALU) and the multiplier control FSM. Under FSM control it loads the multiplier, writes ALU sums into the upper half and shifts right one bit per iteration.

## Interface
- DATA_W, 32, operand width; the product is 2*DATA_W bits.
- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- srl_ctrl  in  1  shift the {carry, product} word right by one bit.
- w_ctrl  in  1  write ALU_result into the upper half and capture ALU_Carry.
- ready  in  1  multiplication finished; freezes the register.
- ALU_Carry  in  1  carry-out of the ALU addition.
- ALU_result  in  DATA_W  ALU sum (upper half plus multiplicand).
- Multiplier_in  in  DATA_W  multiplier operand, loaded at reset.
- Product_out  out  2*DATA_W  current product register contents, driven directly from the flops.

## Operation
- Internal state: P[63:0] drives Product_out; C is a 1-bit carry register.
- All updates happen on the rising edge of clk. Priority, highest first:
  1. reset==0: P <= {32'b0, Multiplier_in}; C <= 0. This is the initialization load and also aborts any multiplication in progress.
  2. ready==1: P and C hold. srl_ctrl and w_ctrl are ignored.
  3. w_ctrl==1 and srl_ctrl==1: P <= {ALU_Carry, ALU_result, P[31:1]}; C <= 0. This is a write-then-shift in one cycle.
  4. w_ctrl==1 only: P[63:32] <= ALU_result; P[31:0] holds; C <= ALU_Carry.
  5. srl_ctrl==1 only: {C, P} <= {1'b0, C, P[63:1]}. The bit shifted out of P[0] is discarded.
  6. Otherwise: hold.
- The control FSM reads the multiplier LSB from Product_out[0].
- After 32 iterations, Product_out is the unsigned 64-bit product.
- No arithmetic is done inside the block. All additions come from the ALU inputs.

## Timing
- Every update has one-cycle latency: the inputs sampled at edge N appear on Product_out immediately after edge N.
- Product_out is registered. There is no combinational path from any input to Product_out.
- Power-up value before the first reset is undefined. After reset, Product_out = {32'b0, Multiplier_in as sampled}.
- Reset asserted together with ready, w_ctrl or srl_ctrl: reset wins.
- ready has priority over the controls, so the result stays stable for as long as ready is high.
- Multiplier_in is sampled only at reset. Changes at any other time have no effect.
- ALU_result and ALU_Carry are sampled only in cycles where w_ctrl is high.

## Configuration
- PRODUCT_CARRY_EN defined:
  - C exists exactly as described in Operation.
  - A right shift brings C into bit 63.
  - A combined write+shift brings ALU_Carry into bit 63.
- PRODUCT_CARRY_EN undefined:
  - C is removed and ALU_Carry is ignored.
  - Every shift brings 0 into bit 63.
  - The product is then correct only if the ALU sum never overflows 32 bits.

## Test plan
- Reset: reset=0, Multiplier_in=0xFFFF_FFFF -> after one edge Product_out=0x0000_0000_FFFF_FFFF.
- Write, then shift without carry: from 0x0000_0000_FFFF_FFFF, w_ctrl=1, ALU_result=10, ALU_Carry=0 -> 0x0000_000A_FFFF_FFFF; next cycle srl_ctrl=1 only -> 0x0000_0005_7FFF_FFFF.
- Carry propagation (PRODUCT_CARRY_EN defined):
  - From 0x0000_0000_FFFF_FFFF, w_ctrl=1, ALU_result=10, ALU_Carry=1 -> 0x0000_000A_FFFF_FFFF.
  - Next cycle srl_ctrl=1 -> 0x8000_0005_7FFF_FFFF.
  - Without the macro the same sequence gives 0x0000_0005_7FFF_FFFF.
- Combined write+shift: from 0x0000_0000_FFFF_FFFF, w_ctrl=srl_ctrl=1, ALU_result=10, ALU_Carry=1 -> 0x8000_0005_7FFF_FFFF.
- Freeze: ready=1 with w_ctrl=srl_ctrl=1 and changing ALU_result -> Product_out unchanged over 3 cycles. Then ready=1 and reset=0 -> reload {0, Multiplier_in}.
- Full multiply: drive the FSM sequence for 0x0000_0003 × 0xFFFF_FFFF (32 iterations) -> Product_out=0x0000_0002_FFFF_FFFD. Assert reset=0 mid-sequence -> reloads and the sequence restarts cleanly.
